// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller.
// The controller keeps tag/valid/dirty state in registers. An external
// synchronous-read data array holds the lines. A single line-level memory
// port is used for victim write-back and for refill.
module dm_cache_ctrl #(
  parameter int INDEX_LEN  = 4,
  parameter int OFFSET_LEN = 2,
  parameter int TAG_LEN    = 8,
  parameter int WORD_W     = 8,
  localparam int LINE_W    = WORD_W << OFFSET_LEN,
  localparam int ADDR_W    = TAG_LEN + INDEX_LEN + OFFSET_LEN
) (
  input  logic                        clk,
  input  logic                        resetn,
  // CPU side
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [WORD_W-1:0]           cpu_wdata,
  output logic                        cpu_ready,
  output logic                        cpu_done,
  output logic [WORD_W-1:0]           cpu_rdata,
  // data array port
  output logic                        arr_write,
  output logic [INDEX_LEN-1:0]        arr_index,
  output logic [LINE_W-1:0]           arr_din,
  input  logic [LINE_W-1:0]           arr_dout,
  // line-level memory port
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [TAG_LEN+INDEX_LEN-1:0] mem_addr,
  output logic [LINE_W-1:0]           mem_wdata,
  input  logic                        mem_ack,
  input  logic [LINE_W-1:0]           mem_rdata,
  // statistics
  output logic [15:0]                 miss_count
);

  localparam int LINES = 1 << INDEX_LEN;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    REFILL    = 3'd3,
    UPDATE    = 3'd4
  } state_t;

  // Extract word 'off' of a line.
  function automatic logic [WORD_W-1:0] get_word(
    input logic [LINE_W-1:0]     line,
    input logic [OFFSET_LEN-1:0] off
  );
    get_word = line[int'(off)*WORD_W +: WORD_W];
  endfunction

  // Replace word 'off' of a line with 'word'.
  function automatic logic [LINE_W-1:0] put_word(
    input logic [LINE_W-1:0]     line,
    input logic [OFFSET_LEN-1:0] off,
    input logic [WORD_W-1:0]     word
  );
    logic [LINE_W-1:0] tmp;
    tmp = line;
    tmp[int'(off)*WORD_W +: WORD_W] = word;
    put_word = tmp;
  endfunction

  state_t                  state_r, state_nxt_s;

  // latched request
  logic [TAG_LEN-1:0]      req_tag_r;
  logic [INDEX_LEN-1:0]    req_idx_r;
  logic [OFFSET_LEN-1:0]   req_off_r;
  logic                    req_we_r;
  logic [WORD_W-1:0]       req_wdata_r;

  // line bookkeeping
  logic [LINES-1:0]        valid_r;
  logic [LINES-1:0]        dirty_r;
  logic [TAG_LEN-1:0]      tag_r [LINES];

  // line buffers
  logic [LINE_W-1:0]       victim_r;
  logic [LINE_W-1:0]       refill_r;

  // registered outputs
  logic                    mem_req_r;
  logic [15:0]             miss_count_r;
  logic                    cpu_done_r;
  logic [WORD_W-1:0]       cpu_rdata_r;

  // combinational helpers
  logic                    hit_s;
  logic                    victim_dirty_s;
  logic                    mem_fire_s;
  logic [LINE_W-1:0]       update_line_s;
  logic                    arr_write_s;
  logic [INDEX_LEN-1:0]    arr_index_s;
  logic [LINE_W-1:0]       arr_din_s;
  logic                    cpu_ready_s;

  // Hit/victim classification and the line written back into the array after refill.
  always_comb begin
    hit_s          = valid_r[req_idx_r] && (tag_r[req_idx_r] == req_tag_r);
    victim_dirty_s = valid_r[req_idx_r] && dirty_r[req_idx_r];
    // An ack only counts while a request is actually outstanding.
    mem_fire_s     = mem_req_r && mem_ack;
    if (req_we_r) begin
      update_line_s = put_word(refill_r, req_off_r, req_wdata_r);
    end else begin
      update_line_s = refill_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state and array-port decode.
  always_comb begin
    state_nxt_s = state_r;
    arr_write_s = 1'b0;
    arr_index_s = req_idx_r;
    arr_din_s   = '0;
    cpu_ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        cpu_ready_s = 1'b1;
        arr_index_s = cpu_addr[OFFSET_LEN +: INDEX_LEN];
        if (cpu_req) begin
          state_nxt_s = LOOKUP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOOKUP: begin
        if (hit_s) begin
          if (req_we_r) begin
            arr_write_s = 1'b1;
            arr_din_s   = put_word(arr_dout, req_off_r, req_wdata_r);
          end else begin
            arr_write_s = 1'b0;
          end
          state_nxt_s = IDLE;
        end else if (victim_dirty_s) begin
          state_nxt_s = WRITEBACK;
        end else begin
          state_nxt_s = REFILL;
        end
      end
      WRITEBACK: begin
        if (mem_fire_s) begin
          state_nxt_s = REFILL;
        end else begin
          state_nxt_s = WRITEBACK;
        end
      end
      REFILL: begin
        if (mem_fire_s) begin
          state_nxt_s = UPDATE;
        end else begin
          state_nxt_s = REFILL;
        end
      end
      UPDATE: begin
        arr_write_s = 1'b1;
        arr_din_s   = update_line_s;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Control registers: line bookkeeping, memory request, completion and miss count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_r      <= '0;
      dirty_r      <= '0;
      mem_req_r    <= 1'b0;
      miss_count_r <= 16'd0;
      cpu_done_r   <= 1'b0;
      cpu_rdata_r  <= '0;
    end else begin
      cpu_done_r <= 1'b0;
      case (state_r)
        LOOKUP: begin
          if (hit_s) begin
            cpu_done_r <= 1'b1;
            if (req_we_r) begin
              dirty_r[req_idx_r] <= 1'b1;
            end else begin
              cpu_rdata_r <= get_word(arr_dout, req_off_r);
            end
          end else begin
            if (miss_count_r != 16'hFFFF) begin
              miss_count_r <= miss_count_r + 16'd1;
            end else begin
              miss_count_r <= miss_count_r;
            end
            mem_req_r <= 1'b1;
          end
        end
        WRITEBACK: begin
          // Drop the request after the ack so it is low for at least one cycle.
          if (mem_fire_s) begin
            mem_req_r <= 1'b0;
          end else begin
            mem_req_r <= 1'b1;
          end
        end
        REFILL: begin
          if (!mem_req_r) begin
            mem_req_r <= 1'b1;
          end else if (mem_ack) begin
            mem_req_r <= 1'b0;
          end else begin
            mem_req_r <= 1'b1;
          end
        end
        UPDATE: begin
          valid_r[req_idx_r] <= 1'b1;
          dirty_r[req_idx_r] <= req_we_r;
          cpu_done_r         <= 1'b1;
          if (!req_we_r) begin
            cpu_rdata_r <= get_word(refill_r, req_off_r);
          end else begin
            cpu_rdata_r <= cpu_rdata_r;
          end
        end
        default: begin
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Datapath registers: request latch, victim/refill buffers and tags (no reset needed, gated by valid).
  always_ff @(posedge clk) begin
    if (state_r == IDLE && cpu_req) begin
      req_tag_r   <= cpu_addr[ADDR_W-1 -: TAG_LEN];
      req_idx_r   <= cpu_addr[OFFSET_LEN +: INDEX_LEN];
      req_off_r   <= cpu_addr[OFFSET_LEN-1:0];
      req_we_r    <= cpu_we;
      req_wdata_r <= cpu_wdata;
    end
    if (state_r == LOOKUP && !hit_s && victim_dirty_s) begin
      victim_r <= arr_dout;
    end
    if (state_r == REFILL && mem_fire_s) begin
      refill_r <= mem_rdata;
    end
    if (state_r == UPDATE && resetn) begin
      tag_r[req_idx_r] <= req_tag_r;
    end
  end

  assign cpu_ready  = cpu_ready_s;
  assign cpu_done   = cpu_done_r;
  assign cpu_rdata  = cpu_rdata_r;
  // A reset cycle must never commit an array write.
  assign arr_write  = arr_write_s & resetn;
  assign arr_index  = arr_index_s;
  assign arr_din    = arr_din_s;
  assign mem_req    = mem_req_r;
  assign mem_we     = (state_r == WRITEBACK);
  assign mem_addr   = (state_r == WRITEBACK) ? {tag_r[req_idx_r], req_idx_r}
                                             : {req_tag_r, req_idx_r};
  assign mem_wdata  = victim_r;
  assign miss_count = miss_count_r;

endmodule
